pkt_ring_sched: RTL and testbench

Packet ring scheduler: accepts captured-packet length descriptors, places each packet in a circular DDR capture ring, and sequences `wr_ctrl` with one packet per transaction. It sits between the capture front-end, which pushes descriptors, and `wr_ctrl`, which bursts FIFO data over Avalon-MM. It keeps the committed producer pointer, handles ring wrap-around, and checks free space against the host consumer pointer.

---
 rtl/pkt_ring_sched_if.sv | 28 ++
 rtl/pkt_ring_sched.sv | 157 +++++++++++++++
 tb/tb_pkt_ring_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pkt_ring_sched_if.sv
// Descriptor, ring-pointer and writer-control bundle for pkt_ring_sched.
// master drives descriptors, the consumer pointer and writer ready; slave is the scheduler.
interface pkt_ring_sched_if;
   logic        desc_valid;
   logic [15:0] desc_len;
   logic        desc_ready;
   logic [31:0] rd_ptr;
   logic [31:0] wr_ptr;
   logic        wr_ctrl;
   logic        wr_ctrl_rdy;
   logic [31:0] pkt_begin;
   logic [31:0] pkt_end;
   logic [31:0] control;
   logic [31:0] drop_cnt;
   logic        busy;

   modport master (
      output desc_valid, desc_len, rd_ptr, wr_ctrl_rdy,
      input  desc_ready, wr_ptr, wr_ctrl, pkt_begin,
      input  pkt_end, control, drop_cnt, busy
   );

   modport slave (
      input  desc_valid, desc_len, rd_ptr, wr_ctrl_rdy,
      output desc_ready, wr_ptr, wr_ctrl, pkt_begin,
      output pkt_end, control, drop_cnt, busy
   );
endinterface

// File: rtl/pkt_ring_sched.sv
// Packet ring scheduler: places descriptors in a circular capture ring and drives wr_ctrl.
// PKT_RING_DROP_EN: drop legal descriptors that do not fit instead of stalling in CHECK.
module pkt_ring_sched #(
   parameter logic [31:0] RING_BASE = 32'h0000_0000,
   parameter logic [31:0] RING_SIZE = 32'h0010_0000,
   parameter int unsigned MAX_PKT   = 2048
) (
   input logic             clk,
   input logic             reset,
   pkt_ring_sched_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT,
      COMMIT
   } state_e;

   localparam logic [31:0] MASK = RING_SIZE - 32'd1;
   localparam logic [31:0] MAXP = MAX_PKT;

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [31:0] off_q, off_d;
   logic        seen_lo_q, seen_lo_d;
   logic [31:0] wr_ptr_q, wr_ptr_d;
   logic [31:0] beg_q, beg_d;
   logic [31:0] end_q, end_d;
   logic [31:0] ctl_q, ctl_d;
   logic [31:0] drop_q, drop_d;
   logic        wr_ctrl_q, wr_ctrl_d;

   logic [31:0] len32;
   logic        illegal;
   logic [31:0] used;
   logic [31:0] free;
   logic        wrap_c;
   logic [31:0] off_c;
   logic [31:0] need;
   logic        fits;
   logic [31:0] drop_inc;
   logic [31:0] end_ofs;

   assign len32    = {16'h0000, len_q};
   assign illegal  = (len_q == 16'd0) || (len_q[1:0] != 2'b00) ||
                     (len32 > MAXP);
   assign used     = (wr_ptr_q - bus.rd_ptr) & MASK;
   // One word is kept empty so a full ring never looks empty.
   assign free     = RING_SIZE - used - 32'd4;
   assign wrap_c   = (wr_ptr_q + len32) > RING_SIZE;
   assign off_c    = wrap_c ? 32'd0 : wr_ptr_q;
   assign need     = wrap_c ? len32 + (RING_SIZE - wr_ptr_q) : len32;
   assign fits     = need <= free;
   assign drop_inc = (&drop_q) ? drop_q : drop_q + 32'd1;
   assign end_ofs  = off_q + len32;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      off_d     = off_q;
      seen_lo_d = seen_lo_q;
      wr_ptr_d  = wr_ptr_q;
      beg_d     = beg_q;
      end_d     = end_q;
      ctl_d     = ctl_q;
      drop_d    = drop_q;
      wr_ctrl_d = wr_ctrl_q;
      unique case (state_q)
         IDLE: begin
            if (bus.desc_valid) begin
               len_d   = bus.desc_len;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (illegal) begin
               drop_d  = drop_inc;
               state_d = IDLE;
            end else if (fits) begin
               off_d   = off_c;
               beg_d   = RING_BASE + off_c;
               end_d   = RING_BASE + off_c + len32;
               ctl_d   = {len_q, 15'h0000, wrap_c};
               state_d = ISSUE;
            end else begin
`ifdef PKT_RING_DROP_EN
               drop_d  = drop_inc;
               state_d = IDLE;
`else
               state_d = CHECK;
`endif
            end
         end
         ISSUE: begin
            if (bus.wr_ctrl_rdy) begin
               wr_ctrl_d = 1'b1;
               seen_lo_d = 1'b0;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            // Completion is a rising ready: low seen first, then high.
            if (!bus.wr_ctrl_rdy) begin
               seen_lo_d = 1'b1;
            end else if (seen_lo_q) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            wr_ctrl_d = 1'b0;
            wr_ptr_d  = (end_ofs == RING_SIZE) ? 32'd0 : end_ofs;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         off_q     <= '0;
         seen_lo_q <= 1'b0;
         wr_ptr_q  <= '0;
         beg_q     <= '0;
         end_q     <= '0;
         ctl_q     <= '0;
         drop_q    <= '0;
         wr_ctrl_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         off_q     <= off_d;
         seen_lo_q <= seen_lo_d;
         wr_ptr_q  <= wr_ptr_d;
         beg_q     <= beg_d;
         end_q     <= end_d;
         ctl_q     <= ctl_d;
         drop_q    <= drop_d;
         wr_ctrl_q <= wr_ctrl_d;
      end
   end

   assign bus.desc_ready = (state_q == IDLE) && !reset;
   assign bus.busy       = (state_q != IDLE);
   assign bus.wr_ptr     = wr_ptr_q;
   assign bus.wr_ctrl    = wr_ctrl_q;
   assign bus.pkt_begin  = beg_q;
   assign bus.pkt_end    = end_q;
   assign bus.control    = ctl_q;
   assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_pkt_ring_sched.sv
// Randomized bench for pkt_ring_sched with a byte-count ring model.
// Ring: base 0x1000, 256 bytes, 64-byte max packet; writer holds ready low 8 cycles.
module tb_pkt_ring_sched;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   int   m_wr;
   int   m_drop;

   pkt_ring_sched_if bus ();

   pkt_ring_sched #(
      .RING_BASE (32'h0000_1000),
      .RING_SIZE (32'd256),
      .MAX_PKT   (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit fits_m(input int rd, input int len);
      int used;
      int free;
      int need;
      used = ((m_wr - rd) % 256 + 256) % 256;
      free = 256 - used - 4;
      need = (m_wr + len > 256) ? len + 256 - m_wr : len;
      return need <= free;
   endfunction

   task automatic do_pkt(input int len, input int rd, input int rd_rel,
                         input bit abort);
      int n;
      int off;
      int wrap;
      bit legal;
      bit stall_ok;
      n = 0;
      while (!bus.desc_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(bus.desc_ready), 32'd1);
      bus.rd_ptr     = 32'(rd);
      bus.desc_valid = 1'b1;
      bus.desc_len   = len[15:0];
      @(negedge clk);
      bus.desc_valid = 1'b0;
      legal = (len > 0) && (len % 4 == 0) && (len <= 64);
      if (!legal) begin
         @(negedge clk);
         m_drop++;
         chk("ill_drop", bus.drop_cnt, 32'(m_drop));
         chk("ill_wrptr", bus.wr_ptr, 32'(m_wr));
         chk("ill_wrctrl", 32'(bus.wr_ctrl), 32'd0);
         chk("ill_ready", 32'(bus.desc_ready), 32'd1);
         return;
      end
      if (!fits_m(rd, len)) begin
`ifdef PKT_RING_DROP_EN
         @(negedge clk);
         m_drop++;
         chk("full_drop", bus.drop_cnt, 32'(m_drop));
         chk("full_wrctrl", 32'(bus.wr_ctrl), 32'd0);
         chk("full_ready", 32'(bus.desc_ready), 32'd1);
         repeat (3) @(negedge clk);
         chk("full_norise", 32'(bus.wr_ctrl), 32'd0);
         return;
`else
         stall_ok = 1'b1;
         repeat (6) begin
            @(negedge clk);
            if (bus.desc_ready || bus.wr_ctrl) stall_ok = 1'b0;
         end
         chk("full_stall", 32'(stall_ok), 32'd1);
         if (rd_rel < 0) rd_rel = m_wr;
         bus.rd_ptr = 32'(rd_rel);
`endif
      end
      wrap = (m_wr + len > 256) ? 1 : 0;
      off  = (wrap != 0) ? 0 : m_wr;
      @(negedge clk);
      chk("issue_begin", bus.pkt_begin, 32'(32'h1000 + off));
      chk("issue_end", bus.pkt_end, 32'(32'h1000 + off + len));
      chk("issue_ctl", bus.control, 32'((len << 16) | wrap));
      chk("issue_wrctrl", 32'(bus.wr_ctrl), 32'd0);
      @(negedge clk);
      chk("wrctrl_rise", 32'(bus.wr_ctrl), 32'd1);
      bus.wr_ctrl_rdy = 1'b0;
      if (abort) begin
         repeat (2) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         m_wr   = 0;
         m_drop = 0;
         chk("rst_wrctrl", 32'(bus.wr_ctrl), 32'd0);
         chk("rst_wrptr", bus.wr_ptr, 32'd0);
         chk("rst_ready", 32'(bus.desc_ready), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_begin", bus.pkt_begin, 32'd0);
         chk("rst_ctl", bus.control, 32'd0);
         chk("rst_drop", bus.drop_cnt, 32'd0);
         reset = 1'b0;
         bus.wr_ctrl_rdy = 1'b1;
         @(negedge clk);
         chk("rst_rel_ready", 32'(bus.desc_ready), 32'd1);
         return;
      end
      repeat (8) @(negedge clk);
      chk("wrctrl_hold", 32'(bus.wr_ctrl), 32'd1);
      bus.wr_ctrl_rdy = 1'b1;
      @(negedge clk);
      chk("commit_wrctrl", 32'(bus.wr_ctrl), 32'd1);
      chk("commit_oldptr", bus.wr_ptr, 32'(m_wr));
      @(negedge clk);
      m_wr = (off + len) % 256;
      chk("done_wrptr", bus.wr_ptr, 32'(m_wr));
      chk("done_wrctrl", 32'(bus.wr_ctrl), 32'd0);
      chk("done_ready", 32'(bus.desc_ready), 32'd1);
      chk("done_drop", bus.drop_cnt, 32'(m_drop));
   endtask

   initial begin
      int len;
      int rd;
      n_chk  = 0;
      n_fail = 0;
      m_wr   = 0;
      m_drop = 0;
      reset  = 1'b1;
      bus.desc_valid  = 1'b0;
      bus.desc_len    = 16'd0;
      bus.rd_ptr      = 32'd0;
      bus.wr_ctrl_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("init_ready", 32'(bus.desc_ready), 32'd0);
      chk("init_wrptr", bus.wr_ptr, 32'd0);
      chk("init_wrctrl", 32'(bus.wr_ctrl), 32'd0);
      chk("init_busy", 32'(bus.busy), 32'd0);
      chk("init_drop", bus.drop_cnt, 32'd0);
      chk("init_begin", bus.pkt_begin, 32'd0);
      chk("init_end", bus.pkt_end, 32'd0);
      chk("init_ctl", bus.control, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("init_rel_ready", 32'(bus.desc_ready), 32'd1);

      do_pkt(32, 0, -1, 1'b0);
      repeat (3) do_pkt(64, m_wr, -1, 1'b0);
      do_pkt(48, 128, -1, 1'b0);
      do_pkt(64, m_wr, -1, 1'b0);
      do_pkt(64, m_wr, -1, 1'b0);
      do_pkt(16, m_wr, -1, 1'b0);
      do_pkt(64, 64, -1, 1'b0);
      do_pkt(64, m_wr, -1, 1'b0);
      do_pkt(64, m_wr, -1, 1'b0);
      do_pkt(8, 132, 144, 1'b0);
      do_pkt(0, m_wr, -1, 1'b0);
      do_pkt(6, m_wr, -1, 1'b0);
      do_pkt(68, m_wr, -1, 1'b0);
      do_pkt(16, m_wr, -1, 1'b1);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 7) len = $urandom_range(1, 16) * 4;
         else if ($urandom_range(0, 2) == 0) len = 0;
         else len = $urandom_range(1, 200);
         if ($urandom_range(0, 1) == 1) rd = m_wr;
         else rd = $urandom_range(0, 63) * 4;
         do_pkt(len, rd, -1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
